// File: rtl/alarm_sensor_fsm.sv
// Alarm sensor front end: sync + debounce of six raw inputs, arm/delay/alarm FSM, frame-stable status.
// Optional build macro ALARM_BLINK_EN makes disp_strobe blink every BLINK_FRAMES frames in ALARM.
module alarm_sensor_fsm #(
    parameter int unsigned DB_CYCLES    = 16,
    parameter int unsigned EXIT_CYCLES  = 64,
    parameter int unsigned ENTRY_CYCLES = 64,
    parameter int unsigned BLINK_FRAMES = 16
) (
    input  logic       clk,
    input  logic       rst_n,
    input  logic [5:0] sens_in,
    input  logic       frame_start,
    output logic [2:0] state,
    output logic [1:0] cause,
    output logic [1:0] disp_cause,
    output logic       disp_strobe
);

    localparam int unsigned DbW    = (DB_CYCLES > 1) ? $clog2(DB_CYCLES) : 1;
    localparam int unsigned MaxDly = (EXIT_CYCLES > ENTRY_CYCLES) ? EXIT_CYCLES : ENTRY_CYCLES;
    localparam int unsigned DlyW   = (MaxDly > 1) ? $clog2(MaxDly) : 1;

    typedef enum logic [2:0] {
        StDisarmed   = 3'd0,
        StExitDelay  = 3'd1,
        StArmed      = 3'd2,
        StEntryDelay = 3'd3,
        StAlarm      = 3'd4
    } state_e;

    logic [5:0]     sync1_q, sync2_q;
    logic [5:0]     db_q, db_d;
    logic [DbW-1:0] db_cnt_q [6];
    logic [DbW-1:0] db_cnt_d [6];

    state_e          state_q, state_d;
    logic [1:0]      cause_q, cause_d;
    logic [DlyW-1:0] dly_q, dly_d;
    logic            strobe_next;

    // Counter restarts whenever the synchronised sample agrees with the debounced value.
    always_comb begin
        db_d = db_q;
        for (int i = 0; i < 6; i++) begin
            db_cnt_d[i] = '0;
            if (sync2_q[i] != db_q[i]) begin
                if (db_cnt_q[i] == DbW'(DB_CYCLES - 1)) begin
                    db_d[i] = sync2_q[i];
                end else begin
                    db_cnt_d[i] = db_cnt_q[i] + DbW'(1);
                end
            end
        end
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            sync1_q <= '0;
            sync2_q <= '0;
            db_q    <= '0;
            for (int i = 0; i < 6; i++) begin
                db_cnt_q[i] <= '0;
            end
        end else begin
            sync1_q  <= sens_in;
            sync2_q  <= sync1_q;
            db_q     <= db_d;
            db_cnt_q <= db_cnt_d;
        end
    end

    logic armed, clr, temp, window, intrusion;
    assign armed     = db_q[0];
    assign window    = db_q[2];
    assign clr       = db_q[3];
    assign temp      = db_q[5];
    assign intrusion = db_q[1] & db_q[4];

    always_comb begin
        state_d = state_q;
        cause_d = cause_q;
        dly_d   = dly_q;
        if (clr) begin
            state_d = StDisarmed;
            cause_d = 2'd0;
            dly_d   = '0;
        end else if (temp || window) begin
            // A lower-priority cause never replaces a higher one already latched.
            state_d = StAlarm;
            if (temp) begin
                cause_d = 2'd3;
            end else if (cause_q < 2'd2) begin
                cause_d = 2'd2;
            end
        end else begin
            case (state_q)
                StDisarmed: begin
                    if (armed) begin
                        state_d = StExitDelay;
                        dly_d   = '0;
                    end
                end
                StExitDelay: begin
                    if (!armed) begin
                        state_d = StDisarmed;
                    end else if (dly_q == DlyW'(EXIT_CYCLES - 1)) begin
                        state_d = StArmed;
                    end else begin
                        dly_d = dly_q + DlyW'(1);
                    end
                end
                StArmed: begin
                    if (!armed) begin
                        state_d = StDisarmed;
                    end else if (intrusion) begin
                        state_d = StEntryDelay;
                        dly_d   = '0;
                    end
                end
                StEntryDelay: begin
                    if (!armed) begin
                        state_d = StDisarmed;
                    end else if (dly_q == DlyW'(ENTRY_CYCLES - 1)) begin
                        state_d = StAlarm;
                        cause_d = 2'd1;
                    end else begin
                        dly_d = dly_q + DlyW'(1);
                    end
                end
                StAlarm: ;
                default: state_d = StDisarmed;
            endcase
        end
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q <= StDisarmed;
            cause_q <= 2'd0;
            dly_q   <= '0;
        end else begin
            state_q <= state_d;
            cause_q <= cause_d;
            dly_q   <= dly_d;
        end
    end

`ifdef ALARM_BLINK_EN
    localparam int unsigned FrmW = $clog2(2 * BLINK_FRAMES);

    logic [FrmW-1:0] frm_cnt_q, frm_cnt_d;

    // First half of each 2*BLINK_FRAMES period shows the alarm colour.
    always_comb begin
        frm_cnt_d   = frm_cnt_q;
        strobe_next = 1'b0;
        if (state_q != StAlarm) begin
            frm_cnt_d = '0;
        end else begin
            strobe_next = (frm_cnt_q < FrmW'(BLINK_FRAMES));
            if (frame_start) begin
                frm_cnt_d = (frm_cnt_q == FrmW'(2 * BLINK_FRAMES - 1)) ? '0
                                                                       : frm_cnt_q + FrmW'(1);
            end
        end
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            frm_cnt_q <= '0;
        end else begin
            frm_cnt_q <= frm_cnt_d;
        end
    end
`else
    assign strobe_next = (state_q == StAlarm);
`endif

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            disp_cause  <= 2'd0;
            disp_strobe <= 1'b0;
        end else if (frame_start) begin
            disp_cause  <= cause_q;
            disp_strobe <= strobe_next;
        end
    end

    assign state = state_q;
    assign cause = cause_q;

endmodule

// File: tb/tb_alarm_sensor_fsm.sv
// Self-checking bench for alarm_sensor_fsm: directed vector table, frame/reset sequences and
// randomized stimulus against a time-stamp based reference model.
module tb_alarm_sensor_fsm;

    localparam int unsigned DB    = 4;
    localparam int unsigned EXITC = 8;
    localparam int unsigned ENTRC = 8;
    localparam int unsigned BLINK = 2;

    logic       clk;
    logic       rst_n;
    logic [5:0] sens_in;
    logic       frame_start;
    logic [2:0] state;
    logic [1:0] cause;
    logic [1:0] disp_cause;
    logic       disp_strobe;

    alarm_sensor_fsm #(
        .DB_CYCLES   (DB),
        .EXIT_CYCLES (EXITC),
        .ENTRY_CYCLES(ENTRC),
        .BLINK_FRAMES(BLINK)
    ) dut (
        .clk        (clk),
        .rst_n      (rst_n),
        .sens_in    (sens_in),
        .frame_start(frame_start),
        .state      (state),
        .cause      (cause),
        .disp_cause (disp_cause),
        .disp_strobe(disp_strobe)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    int n_checks = 0;
    int n_fail   = 0;

    task automatic check(input string name, input int got, input int exp);
        n_checks++;
        if (got != exp) begin
            n_fail++;
            $display("FAIL %s: got %0d expected %0d at %0t", name, got, exp, $time);
        end
    endtask

    // Reference model: raw history through a two-sample delay, run-length debounce,
    // and delay states timed by the cycle number at which they were entered.
    logic [5:0] m_s1, m_s2, m_db;
    int m_run [6];
    int m_state, m_cause, m_dcause, m_dstrobe, m_frames;
    longint m_cyc, m_t_enter;

    task automatic model_reset();
        m_s1 = '0; m_s2 = '0; m_db = '0;
        for (int i = 0; i < 6; i++) m_run[i] = 0;
        m_state = 0; m_cause = 0; m_dcause = 0; m_dstrobe = 0; m_frames = 0;
        m_t_enter = m_cyc;
    endtask

    task automatic model_step(input logic [5:0] raw, input logic fs);
        int ns, nc;
        logic armed, win, clr, temp, intr;
        m_cyc++;
        if (m_state != 4) m_frames = 0;
        if (fs) begin
            m_dcause = m_cause;
            if (m_state == 4) begin
`ifdef ALARM_BLINK_EN
                m_dstrobe = ((m_frames / BLINK) % 2 == 0) ? 1 : 0;
`else
                m_dstrobe = 1;
`endif
                m_frames++;
            end else begin
                m_dstrobe = 0;
            end
        end
        armed = m_db[0]; win = m_db[2]; clr = m_db[3]; temp = m_db[5];
        intr = m_db[1] & m_db[4];
        ns = m_state; nc = m_cause;
        if (clr) begin
            ns = 0; nc = 0;
        end else if (temp || win) begin
            ns = 4;
            if (temp) nc = 3;
            else if (nc < 2) nc = 2;
        end else begin
            case (m_state)
                0: if (armed) ns = 1;
                1: if (!armed) ns = 0; else if (m_cyc - m_t_enter >= EXITC) ns = 2;
                2: if (!armed) ns = 0; else if (intr) ns = 3;
                3: begin
                    if (!armed) ns = 0;
                    else if (m_cyc - m_t_enter >= ENTRC) begin ns = 4; nc = 1; end
                end
                default: ;
            endcase
        end
        if (ns != m_state) m_t_enter = m_cyc;
        m_state = ns; m_cause = nc;
        for (int i = 0; i < 6; i++) begin
            if (m_s2[i] != m_db[i]) begin
                m_run[i]++;
                if (m_run[i] == DB) begin
                    m_db[i]  = m_s2[i];
                    m_run[i] = 0;
                end
            end else begin
                m_run[i] = 0;
            end
        end
        m_s2 = m_s1;
        m_s1 = raw;
    endtask

    task automatic tick(input logic [5:0] s, input logic fs);
        sens_in     = s;
        frame_start = fs;
        @(posedge clk);
        model_step(s, fs);
        #1;
        check("model state", int'(state), m_state);
        check("model cause", int'(cause), m_cause);
        check("model disp_cause", int'(disp_cause), m_dcause);
        check("model disp_strobe", int'(disp_strobe), m_dstrobe);
        frame_start = 1'b0;
    endtask

    typedef struct {
        logic [5:0] sens;
        int         cycles;
        int         st;
        int         cs;
    } vec_t;

    vec_t vecs [30];
    int   pat  [5];

    initial begin
        // sens bits: 1 armed, 2 door, 4 window, 8 clear, 16 motion, 32 temperature
        vecs[0]  = '{6'd4,  6,  0, 0};
        vecs[1]  = '{6'd4,  1,  4, 2};
        vecs[2]  = '{6'd8,  6,  4, 2};
        vecs[3]  = '{6'd8,  1,  0, 0};
        vecs[4]  = '{6'd0,  10, 0, 0};
        vecs[5]  = '{6'd4,  3,  0, 0};
        vecs[6]  = '{6'd0,  10, 0, 0};
        vecs[7]  = '{6'd1,  6,  0, 0};
        vecs[8]  = '{6'd1,  1,  1, 0};
        vecs[9]  = '{6'd19, 7,  1, 0};
        vecs[10] = '{6'd19, 1,  2, 0};
        vecs[11] = '{6'd19, 1,  3, 0};
        vecs[12] = '{6'd1,  7,  3, 0};
        vecs[13] = '{6'd1,  1,  4, 1};
        vecs[14] = '{6'd0,  10, 4, 1};
        vecs[15] = '{6'd32, 6,  4, 1};
        vecs[16] = '{6'd32, 1,  4, 3};
        vecs[17] = '{6'd36, 8,  4, 3};
        vecs[18] = '{6'd44, 6,  4, 3};
        vecs[19] = '{6'd44, 1,  0, 0};
        vecs[20] = '{6'd36, 6,  0, 0};
        vecs[21] = '{6'd36, 1,  4, 3};
        vecs[22] = '{6'd8,  7,  0, 0};
        vecs[23] = '{6'd0,  10, 0, 0};
        vecs[24] = '{6'd1,  7,  1, 0};
        vecs[25] = '{6'd1,  8,  2, 0};
        vecs[26] = '{6'd19, 7,  3, 0};
        vecs[27] = '{6'd18, 4,  3, 0};
        vecs[28] = '{6'd18, 3,  0, 0};
        vecs[29] = '{6'd0,  10, 0, 0};
`ifdef ALARM_BLINK_EN
        pat = '{1, 1, 0, 0, 1};
`else
        pat = '{1, 1, 1, 1, 1};
`endif

        m_cyc = 0;
        model_reset();
        rst_n       = 1'b0;
        sens_in     = '0;
        frame_start = 1'b0;
        repeat (2) @(posedge clk);
        #1;
        check("reset state", int'(state), 0);
        check("reset cause", int'(cause), 0);
        check("reset disp_cause", int'(disp_cause), 0);
        check("reset disp_strobe", int'(disp_strobe), 0);
        @(negedge clk);
        rst_n = 1'b1;

        for (int v = 0; v < 30; v++) begin
            for (int c = 0; c < vecs[v].cycles; c++) tick(vecs[v].sens, 1'b0);
            check($sformatf("vec%0d state", v), int'(state), vecs[v].st);
            check($sformatf("vec%0d cause", v), int'(cause), vecs[v].cs);
        end

        // Alarm raised mid-frame: display holds until the next frame_start.
        repeat (7) tick(6'd4, 1'b0);
        check("frame alarm state", int'(state), 4);
        check("frame hold disp_cause", int'(disp_cause), 0);
        repeat (3) tick(6'd4, 1'b0);
        check("frame hold2 disp_cause", int'(disp_cause), 0);
        check("frame hold disp_strobe", int'(disp_strobe), 0);
        for (int f = 0; f < 5; f++) begin
            tick(6'd4, 1'b1);
            check($sformatf("frame%0d disp_cause", f), int'(disp_cause), 2);
            check($sformatf("frame%0d disp_strobe", f), int'(disp_strobe), pat[f]);
            repeat (3) tick(6'd4, 1'b0);
            check($sformatf("frame%0d strobe hold", f), int'(disp_strobe), pat[f]);
        end

        // Asynchronous reset in ALARM, between clock edges.
        #2;
        rst_n = 1'b0;
        #1;
        check("async state", int'(state), 0);
        check("async cause", int'(cause), 0);
        check("async disp_cause", int'(disp_cause), 0);
        check("async disp_strobe", int'(disp_strobe), 0);
        model_reset();
        @(negedge clk);
        rst_n = 1'b1;
        repeat (5) tick(6'd0, 1'b0);
        check("post reset state", int'(state), 0);
        repeat (7) tick(6'd1, 1'b0);
        check("post reset exit", int'(state), 1);

        begin
            logic [5:0] s;
            s = 6'd1;
            for (int n = 0; n < 3000; n++) begin
                if ($urandom_range(0, 4) == 0) s[$urandom_range(0, 5)] ^= 1'b1;
                if (s[3] && $urandom_range(0, 3) == 0) s[3] = 1'b0;
                tick(s, ($urandom_range(0, 7) == 0));
            end
        end

        $display("TB_RESULT checks=%0d failures=%0d", n_checks, n_fail);
        $finish;
    end

endmodule
